// File: rtl/rs_switch_pkg.sv
// Shared encodings and request resolution for the photonic switch latch bank.
package rs_switch_pkg;

  // S&R-both-high resolution modes
  localparam int unsigned MODE_RST_DOM = 0;
  localparam int unsigned MODE_SET_DOM = 1;
  localparam int unsigned MODE_HOLD    = 2;
  localparam int unsigned MODE_TOGGLE  = 3;

  typedef struct packed {
    logic valid;
    logic target;
  } req_t;

  // Turn one channel's S/R pair into a request; base is the state a toggle flips.
  function automatic req_t resolve(input logic s, input logic r, input int unsigned mode,
                                   input logic base);
    req_t req;
    req.valid  = 1'b0;
    req.target = 1'b0;
    case ({s, r})
      2'b10: begin
        req.valid  = 1'b1;
        req.target = 1'b1;
      end
      2'b01: begin
        req.valid  = 1'b1;
        req.target = 1'b0;
      end
      2'b11: begin
        case (mode)
          MODE_RST_DOM: begin
            req.valid  = 1'b1;
            req.target = 1'b0;
          end
          MODE_SET_DOM: begin
            req.valid  = 1'b1;
            req.target = 1'b1;
          end
          MODE_TOGGLE: begin
            req.valid  = 1'b1;
            req.target = ~base;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    return req;
  endfunction

endpackage

// File: rtl/rs_switch_channel.sv
// One switch channel: latch, settle counter, one-deep pending buffer.
// Optional macro RS_SWITCH_EDGE_EN makes S/R rising-edge sensitive (+1 cycle latency).
module rs_switch_channel
  import rs_switch_pkg::*;
#(
  parameter int unsigned DWELL_W = 8,
  parameter int unsigned MODE    = MODE_RST_DOM
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s,
  input  logic               r,
  input  logic [DWELL_W-1:0] dwell,
  output logic               out,
  output logic               busy,
  output logic               conflict
);

  localparam logic [DWELL_W-1:0] CntOne = DWELL_W'(1);

  logic               s_req, r_req;
  logic               out_q, out_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               pend_valid_q, pend_valid_d;
  logic               pend_tgt_q, pend_tgt_d;
  logic               conflict_q;
  logic               base;
  req_t               req;

`ifdef RS_SWITCH_EDGE_EN
  logic s_prev_q, r_prev_q, s_edge_q, r_edge_q;

  // Registered rising-edge detect; a held input yields a single request
  always_ff @(posedge clk) begin
    if (reset) begin
      s_prev_q <= 1'b0;
      r_prev_q <= 1'b0;
      s_edge_q <= 1'b0;
      r_edge_q <= 1'b0;
    end else begin
      s_prev_q <= s;
      r_prev_q <= r;
      s_edge_q <= s & ~s_prev_q;
      r_edge_q <= r & ~r_prev_q;
    end
  end

  assign s_req = s_edge_q;
  assign r_req = r_edge_q;
`else
  assign s_req = s;
  assign r_req = r;
`endif

  // Toggle flips the most recent intended state, i.e. the pending target if any
  assign base = pend_valid_q ? pend_tgt_q : out_q;
  assign req  = resolve(s_req, r_req, MODE, base);

  // Next-state: apply when idle, buffer while settling, replay pending on expiry
  always_comb begin
    out_d        = out_q;
    cnt_d        = cnt_q;
    pend_valid_d = pend_valid_q;
    pend_tgt_d   = pend_tgt_q;
    if (cnt_q == '0) begin
      if (req.valid && (req.target != out_q)) begin
        out_d = req.target;
        cnt_d = dwell;
      end
    end else if (cnt_q == CntOne) begin
      // Expiry: a fresh request beats the buffered one
      pend_valid_d = 1'b0;
      cnt_d        = '0;
      if (req.valid) begin
        if (req.target != out_q) begin
          out_d = req.target;
          cnt_d = dwell;
        end
      end else if (pend_valid_q && (pend_tgt_q != out_q)) begin
        out_d = pend_tgt_q;
        cnt_d = dwell;
      end
    end else begin
      cnt_d = cnt_q - CntOne;
      if (req.valid) begin
        if (req.target == out_q) begin
          pend_valid_d = 1'b0;
        end else begin
          pend_valid_d = 1'b1;
          pend_tgt_d   = req.target;
        end
      end
    end
  end

  // State registers with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q        <= 1'b0;
      cnt_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_tgt_q   <= 1'b0;
      conflict_q   <= 1'b0;
    end else begin
      out_q        <= out_d;
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_tgt_q   <= pend_tgt_d;
      conflict_q   <= s_req & r_req;
    end
  end

  assign out      = out_q;
  assign busy     = (cnt_q != '0);
  assign conflict = conflict_q;

endmodule

// File: rtl/rs_switch_bank.sv
// Bank of N_CH independent set/reset switch channels with settle timing.
// Optional macro RS_SWITCH_EDGE_EN selects edge-sensitive S/R in every channel.
module rs_switch_bank
  import rs_switch_pkg::*;
#(
  parameter int unsigned N_CH    = 8,
  parameter int unsigned DWELL_W = 8,
  parameter int unsigned MODE    = MODE_RST_DOM
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_CH-1:0]    S,
  input  logic [N_CH-1:0]    R,
  input  logic [DWELL_W-1:0] dwell,
  output logic [N_CH-1:0]    out,
  output logic [N_CH-1:0]    busy,
  output logic [N_CH-1:0]    conflict
);

  // One channel instance per control line
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    rs_switch_channel #(
      .DWELL_W(DWELL_W),
      .MODE   (MODE)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .s       (S[i]),
      .r       (R[i]),
      .dwell   (dwell),
      .out     (out[i]),
      .busy    (busy[i]),
      .conflict(conflict[i])
    );
  end

endmodule

// File: tb/tb_rs_switch_bank.sv
// Self-checking bench for rs_switch_bank (level-sensitive build).
module tb_rs_switch_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] s = '0;
  logic [7:0] r = '0;
  logic [7:0] dwell = '0;
  logic [7:0] out0, busy0, conf0;
  logic [7:0] out1, busy1, conf1;
  logic [7:0] out3, busy3, conf3;

  always #5 clk = ~clk;

  rs_switch_bank #(.N_CH(8), .DWELL_W(8), .MODE(0)) u_dut0 (
    .clk(clk), .reset(reset), .S(s), .R(r), .dwell(dwell),
    .out(out0), .busy(busy0), .conflict(conf0)
  );
  rs_switch_bank #(.N_CH(8), .DWELL_W(8), .MODE(1)) u_dut1 (
    .clk(clk), .reset(reset), .S(s), .R(r), .dwell(dwell),
    .out(out1), .busy(busy1), .conflict(conf1)
  );
  rs_switch_bank #(.N_CH(8), .DWELL_W(8), .MODE(3)) u_dut3 (
    .clk(clk), .reset(reset), .S(s), .R(r), .dwell(dwell),
    .out(out3), .busy(busy3), .conflict(conf3)
  );

  typedef struct {
    string      name;
    logic [7:0] out;
    logic [7:0] busy;
    logic [7:0] conf;
    logic [7:0] out1;
    logic [7:0] busy1;
    logic [7:0] out3;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick(input logic [7:0] sv, input logic [7:0] rv);
    s = sv;
    r = rv;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(8'h00, 8'h00);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      reset = (i < 2);
      sb.push_back('{name: "reset", out: 8'h00, busy: 8'h00, conf: 8'h00,
                     out1: 8'h00, busy1: 8'h00, out3: 8'h00});
      if (i < 2) tick(8'($urandom), 8'($urandom));
      else tick(8'h00, 8'h00);
      e = sb.pop_front();
      checks++;
      if ({out0, busy0, conf0, out1, busy1, out3} !==
          {e.out, e.busy, e.conf, e.out1, e.busy1, e.out3}) begin
        errors++;
        $display("FAIL %s cyc %0d: got out=%h busy=%h conf=%h out1=%h busy1=%h out3=%h, want 0",
                 e.name, i, out0, busy0, conf0, out1, busy1, out3);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] sv[5] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] ov[5] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    logic [7:0] bv[5] = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h00};
    exp_t e;
    do_reset();
    dwell = 8'd3;
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{name: "single", out: ov[i], busy: bv[i], conf: 8'h00,
                     out1: 8'h00, busy1: 8'h00, out3: 8'h00});
      tick(sv[i], 8'h00);
      e = sb.pop_front();
      checks++;
      if ({out0, busy0, conf0} !== {e.out, e.busy, e.conf}) begin
        errors++;
        $display("FAIL %s cyc %0d: got out=%h busy=%h conf=%h, want out=%h busy=%h conf=%h",
                 e.name, i, out0, busy0, conf0, e.out, e.busy, e.conf);
      end
    end
  endtask

  task automatic test_pending();
    logic [7:0] sv[7] = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] rv[7] = '{8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] ov[7] = '{8'h04, 8'h04, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] bv[7] = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h00};
    exp_t e;
    do_reset();
    dwell = 8'd3;
    for (int i = 0; i < 7; i++) begin
      sb.push_back('{name: "pending", out: ov[i], busy: bv[i], conf: 8'h00,
                     out1: 8'h00, busy1: 8'h00, out3: 8'h00});
      tick(sv[i], rv[i]);
      e = sb.pop_front();
      checks++;
      if ({out0, busy0, conf0} !== {e.out, e.busy, e.conf}) begin
        errors++;
        $display("FAIL %s cyc %0d: got out=%h busy=%h conf=%h, want out=%h busy=%h conf=%h",
                 e.name, i, out0, busy0, conf0, e.out, e.busy, e.conf);
      end
    end
  endtask

  task automatic test_modes();
    logic [7:0] sv[7]  = '{8'h02, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h02};
    logic [7:0] rv[7]  = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h02};
    logic [7:0] ov[7]  = '{8'h02, 8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] bv[7]  = '{8'h02, 8'h02, 8'h00, 8'h02, 8'h02, 8'h00, 8'h00};
    logic [7:0] cv[7]  = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h02};
    logic [7:0] o1v[7] = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02};
    logic [7:0] b1v[7] = '{8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] o3v[7] = '{8'h02, 8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'h02};
    exp_t e;
    do_reset();
    dwell = 8'd2;
    for (int i = 0; i < 7; i++) begin
      sb.push_back('{name: "modes", out: ov[i], busy: bv[i], conf: cv[i],
                     out1: o1v[i], busy1: b1v[i], out3: o3v[i]});
      tick(sv[i], rv[i]);
      e = sb.pop_front();
      checks++;
      if ({out0, busy0, conf0, out1, busy1, out3} !==
          {e.out, e.busy, e.conf, e.out1, e.busy1, e.out3}) begin
        errors++;
        $display("FAIL %s cyc %0d: got %h %h %h %h %h %h, want %h %h %h %h %h %h",
                 e.name, i, out0, busy0, conf0, out1, busy1, out3,
                 e.out, e.busy, e.conf, e.out1, e.busy1, e.out3);
      end
    end
  endtask

  task automatic test_dwell_zero();
    exp_t e;
    do_reset();
    dwell = 8'd0;
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{name: "dwell0", out: (i % 2 == 0) ? 8'h08 : 8'h00, busy: 8'h00,
                     conf: 8'h00, out1: 8'h00, busy1: 8'h00, out3: 8'h00});
      if (i % 2 == 0) tick(8'h08, 8'h00);
      else tick(8'h00, 8'h08);
      e = sb.pop_front();
      checks++;
      if ({out0, busy0, conf0} !== {e.out, e.busy, e.conf}) begin
        errors++;
        $display("FAIL %s cyc %0d: got out=%h busy=%h conf=%h, want out=%h busy=%h conf=%h",
                 e.name, i, out0, busy0, conf0, e.out, e.busy, e.conf);
      end
    end
  endtask

  task automatic test_reset_mid_dwell();
    logic [7:0] sv[15] = '{8'h10, 0, 0, 0, 0, 0, 8'h00, 8'h10, 0, 0, 0, 0, 0, 0, 0};
    logic [7:0] rv[15] = '{8'h00, 0, 0, 0, 0, 0, 8'h10, 8'h00, 0, 0, 0, 0, 0, 0, 0};
    logic [7:0] ov[15] = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [7:0] bv[15] = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00, 8'h10, 8'h10,
                           0, 0, 0, 0, 0, 0, 0};
    exp_t e;
    do_reset();
    dwell = 8'd5;
    for (int i = 0; i < 15; i++) begin
      reset = (i == 8);
      sb.push_back('{name: "reset_mid", out: ov[i], busy: bv[i], conf: 8'h00,
                     out1: 8'h00, busy1: 8'h00, out3: 8'h00});
      tick(sv[i], rv[i]);
      e = sb.pop_front();
      checks++;
      if ({out0, busy0, conf0} !== {e.out, e.busy, e.conf}) begin
        errors++;
        $display("FAIL %s cyc %0d: got out=%h busy=%h conf=%h, want out=%h busy=%h conf=%h",
                 e.name, i, out0, busy0, conf0, e.out, e.busy, e.conf);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_pending_cancel();
    logic [7:0] sv[5] = '{8'h20, 8'h00, 8'h20, 8'h00, 8'h00};
    logic [7:0] rv[5] = '{8'h00, 8'h20, 8'h00, 8'h00, 8'h00};
    logic [7:0] bv[5] = '{8'h20, 8'h20, 8'h20, 8'h00, 8'h00};
    exp_t e;
    do_reset();
    dwell = 8'd3;
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{name: "cancel", out: 8'h20, busy: bv[i], conf: 8'h00,
                     out1: 8'h00, busy1: 8'h00, out3: 8'h00});
      tick(sv[i], rv[i]);
      e = sb.pop_front();
      checks++;
      if ({out0, busy0, conf0} !== {e.out, e.busy, e.conf}) begin
        errors++;
        $display("FAIL %s cyc %0d: got out=%h busy=%h conf=%h, want out=%h busy=%h conf=%h",
                 e.name, i, out0, busy0, conf0, e.out, e.busy, e.conf);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] sv[3] = '{8'hff, 8'h00, 8'h00};
    logic [7:0] rv[3] = '{8'h00, 8'hff, 8'h00};
    logic [7:0] ov[3] = '{8'hff, 8'h00, 8'h00};
    logic [7:0] bv[3] = '{8'hff, 8'hff, 8'h00};
    exp_t e;
    do_reset();
    dwell = 8'd1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{name: "all_ch", out: ov[i], busy: bv[i], conf: 8'h00,
                     out1: 8'h00, busy1: 8'h00, out3: 8'h00});
      tick(sv[i], rv[i]);
      e = sb.pop_front();
      checks++;
      if ({out0, busy0, conf0} !== {e.out, e.busy, e.conf}) begin
        errors++;
        $display("FAIL %s cyc %0d: got out=%h busy=%h conf=%h, want out=%h busy=%h conf=%h",
                 e.name, i, out0, busy0, conf0, e.out, e.busy, e.conf);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_pending();
    test_modes();
    test_dwell_zero();
    test_reset_mid_dwell();
    test_pending_cancel();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
